// File: rtl/hex_event_stream_writer.sv
`default_nettype none
// ============================================================================
// Module   : hex_event_stream_writer
// Desc     : Queues hex-cell events in a FIFO and streams packed 64-bit
//            records into a per-frame memory buffer with capacity limiting,
//            drop accounting and frame-boundary draining.
//            Optional macro HEX_EVENT_SEQ_EN stores a per-frame sequence
//            number in each record tail.
// Revision : 1.0 - initial release
// ============================================================================
module hex_event_stream_writer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int ADDR_W      = 32,
    parameter int ADDR_STRIDE = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] buffer_base,
    input  logic [CNT_W-1:0]  buffer_limit,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       q,
    input  logic [15:0]       r,
    input  logic [7:0]        depth,
    input  logic [7:0]        material,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_data,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  event_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              overflow,
    output logic              busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
`ifdef HEX_EVENT_SEQ_EN
    localparam int ENTRY_W = 64;
`else
    localparam int ENTRY_W = 48;
`endif
    localparam logic [OCC_W-1:0]  FULL_OCC = OCC_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(ADDR_STRIDE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic [ENTRY_W-1:0]  fifo_mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]   write_ptr_q, write_ptr_d;
    logic [CNT_W-1:0]    limit_q, limit_d;
    logic [CNT_W-1:0]    event_count_q, event_count_d;
    logic [CNT_W-1:0]    drop_count_q, drop_count_d;
    logic                overflow_q, overflow_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [63:0]         mem_data_q, mem_data_d;
    logic                mem_we_q, mem_we_d;

    logic                fifo_empty;
    logic                fifo_full;
    logic                accept;
    logic                push;
    logic                drop;
    logic                pop;
    logic                rebase;
    logic [ENTRY_W-1:0]  entry_in;
    logic [ENTRY_W-1:0]  head;
    logic [63:0]         head_record;

    assign head = fifo_mem_q[rd_ptr_q];

`ifdef HEX_EVENT_SEQ_EN
    logic [15:0] seq_num;
    if (CNT_W >= 16) begin : g_seq_wide
        assign seq_num = event_count_q[15:0];
    end else begin : g_seq_narrow
        assign seq_num = {{(16-CNT_W){1'b0}}, event_count_q};
    end
    assign entry_in    = {q, r, depth, material, seq_num};
    assign head_record = head;
`else
    assign entry_in    = {q, r, depth, material};
    assign head_record = {head, 16'h0000};
`endif

    // in_ready depends only on registered occupancy, so a push never meets a full FIFO
    assign fifo_empty = (occ_q == '0);
    assign fifo_full  = (occ_q == FULL_OCC);
    assign in_ready   = (state_q == ST_RUN) && !fifo_full && !frame_start;
    assign accept     = in_valid && in_ready;
    assign push       = accept && (event_count_q < limit_q);
    assign drop       = accept && !push;
    assign pop        = !fifo_empty && (!mem_we_q || mem_ready);

    always_comb begin
        state_d = state_q;
        rebase  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    rebase  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (frame_start) begin
                    if (fifo_empty && !mem_we_q) begin
                        rebase = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave on the edge that retires the final write; later pulses are ignored
                if (fifo_empty && (!mem_we_q || mem_ready)) begin
                    rebase  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        occ_d         = occ_q;
        write_ptr_d   = write_ptr_q;
        limit_d       = limit_q;
        event_count_d = event_count_q;
        drop_count_d  = drop_count_q;
        overflow_d    = overflow_q;
        mem_addr_d    = mem_addr_q;
        mem_data_d    = mem_data_q;
        mem_we_d      = mem_we_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (event_count_q != '1) begin
                event_count_d = event_count_q + CNT_W'(1);
            end
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + CNT_W'(1);
            end
        end

        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            mem_addr_d  = write_ptr_q;
            mem_data_d  = head_record;
            mem_we_d    = 1'b1;
            write_ptr_d = write_ptr_q + STRIDE;
        end else if (mem_we_q && mem_ready) begin
            mem_we_d = 1'b0;
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        // Rebase only fires with the pipeline idle, so it never collides with push/pop
        if (rebase) begin
            write_ptr_d   = buffer_base;
            limit_d       = buffer_limit;
            event_count_d = '0;
            drop_count_d  = '0;
            overflow_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            occ_q         <= '0;
            write_ptr_q   <= '0;
            limit_q       <= '0;
            event_count_q <= '0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            mem_we_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            occ_q         <= occ_d;
            write_ptr_q   <= write_ptr_d;
            limit_q       <= limit_d;
            event_count_q <= event_count_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
            mem_we_q      <= mem_we_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= entry_in;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_data    = mem_data_q;
    assign mem_we      = mem_we_q;
    assign event_count = event_count_q;
    assign drop_count  = drop_count_q;
    assign overflow    = overflow_q;
    assign busy        = !fifo_empty || mem_we_q || (state_q == ST_DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_hex_event_stream_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_event_stream_writer
// Desc     : Cycle-vector table plus scoreboard sequences for backpressure,
//            frame draining, address wrap, zero limit and mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_event_stream_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, frame_start, in_valid, mem_ready;
    logic [31:0] buffer_base;
    logic [15:0] buffer_limit;
    logic [15:0] ev_q, ev_r;
    logic [7:0]  ev_depth, ev_mat;

    logic        in_ready, mem_we, overflow, busy;
    logic [31:0] mem_addr;
    logic [63:0] mem_data;
    logic [15:0] event_count, drop_count;

    logic        in_ready8, mem_we8, overflow8, busy8;
    logic [31:0] mem_addr8;
    logic [63:0] mem_data8;
    logic [15:0] event_count8, drop_count8;

    hex_event_stream_writer dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
        .buffer_base(buffer_base), .buffer_limit(buffer_limit),
        .in_valid(in_valid), .in_ready(in_ready),
        .q(ev_q), .r(ev_r), .depth(ev_depth), .material(ev_mat),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ready(mem_ready),
        .event_count(event_count), .drop_count(drop_count),
        .overflow(overflow), .busy(busy)
    );

    hex_event_stream_writer #(.ADDR_STRIDE(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
        .buffer_base(buffer_base), .buffer_limit(buffer_limit),
        .in_valid(in_valid), .in_ready(in_ready8),
        .q(ev_q), .r(ev_r), .depth(ev_depth), .material(ev_mat),
        .mem_addr(mem_addr8), .mem_data(mem_data8), .mem_we(mem_we8), .mem_ready(mem_ready),
        .event_count(event_count8), .drop_count(drop_count8),
        .overflow(overflow8), .busy(busy8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rec(input logic [15:0] fq_v, input logic [15:0] fr_v,
                                        input logic [7:0] fd_v, input logic [7:0] fm_v,
                                        input logic [15:0] seq);
`ifdef HEX_EVENT_SEQ_EN
        return {fq_v, fr_v, fd_v, fm_v, seq};
`else
        return {fq_v, fr_v, fd_v, fm_v, 16'h0000} | {48'h0, seq & 16'h0000};
`endif
    endfunction

    function automatic logic [15:0] fq(input int k); return 16'(32'h0100 + k);     endfunction
    function automatic logic [15:0] fr(input int k); return 16'(32'hF000 - 3 * k); endfunction
    function automatic logic [7:0]  fd(input int k); return 8'(7 * k);             endfunction
    function automatic logic [7:0]  fm(input int k); return 8'(32'hC0 ^ k);        endfunction

    typedef struct {
        logic        fs;
        logic [31:0] base;
        logic [15:0] lim;
        logic        v;
        logic [15:0] eq, er;
        logic [7:0]  ed, em;
        logic        mr;
        logic        rdy, we;
        logic [31:0] addr;
        logic [15:0] dq, dr;
        logic [7:0]  dd, dm;
        logic [15:0] dseq;
        logic [15:0] ec, dc;
        logic        ovf, bsy;
    } vec_t;
    vec_t tv [14];

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } wr_t;
    wr_t         sb_q[$];
    logic [31:0] addr8_q[$];
    int          wr_cnt = 0;
    bit          mon_en = 1'b0;
    logic [31:0] sb_base;
    int          sb_idx, sb_lim;

    always @(negedge clk) begin : mon
        wr_t e;
        if (mem_we8 && mem_ready) addr8_q.push_back(mem_addr8);
        if (mon_en && mem_we && mem_ready) begin
            wr_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_write", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(e.addr));
                chk("wr_data", mem_data, e.data);
            end
        end
    end

    task automatic step(input logic fs, input logic [31:0] base, input logic [15:0] lim,
                        input logic v, input int k, input logic mr, output logic acc);
        frame_start  = fs;
        buffer_base  = base;
        buffer_limit = lim;
        in_valid     = v;
        ev_q         = fq(k);
        ev_r         = fr(k);
        ev_depth     = fd(k);
        ev_mat       = fm(k);
        mem_ready    = mr;
        #3;
        acc = v && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic mr, output logic acc);
        wr_t e;
        step(1'b0, sb_base, 16'(sb_lim), 1'b1, k, mr, acc);
        if (acc && sb_idx < sb_lim) begin
            e.addr = sb_base + 32'(sb_idx);
            e.data = rec(fq(k), fr(k), fd(k), fm(k), 16'(sb_idx));
            sb_q.push_back(e);
            sb_idx++;
        end
    endtask

    task automatic new_frame(input logic [31:0] base, input int lim);
        logic acc;
        step(1'b1, base, 16'(lim), 1'b0, 0, 1'b1, acc);
        sb_base = base;
        sb_idx  = 0;
        sb_lim  = lim;
    endtask

    task automatic flush(input string nm);
        logic acc;
        int   n = 0;
        while ((sb_q.size() != 0 || mem_we) && n < 60) begin
            step(1'b0, sb_base, 16'(sb_lim), 1'b0, 0, 1'b1, acc);
            n++;
        end
        chk(nm, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   n_acc;
        int   i;

        //           fs    base          lim   v   eq        er        ed     em     mr    rdy   we    addr          dq        dr        dd     dm     seq     ec     dc     ovf   bsy
        tv[0]  = '{1'b1, 32'h1000, 16'd8, 1'b0, 16'h0000, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 32'h1000, 16'd8, 1'b1, 16'h0001, 16'hFFFE, 8'h03, 8'h04, 1'b1, 1'b1, 1'b0, 32'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00, 16'd0, 16'd1, 16'd0, 1'b0, 1'b1};
        tv[2]  = '{1'b0, 32'h1000, 16'd8, 1'b1, 16'hFF9C, 16'h00C8, 8'h10, 8'h20, 1'b1, 1'b1, 1'b1, 32'h1000, 16'h0001, 16'hFFFE, 8'h03, 8'h04, 16'd0, 16'd2, 16'd0, 1'b0, 1'b1};
        tv[3]  = '{1'b0, 32'h1000, 16'd8, 1'b1, 16'h7FFF, 16'h8000, 8'hFF, 8'h01, 1'b1, 1'b1, 1'b1, 32'h1001, 16'hFF9C, 16'h00C8, 8'h10, 8'h20, 16'd1, 16'd3, 16'd0, 1'b0, 1'b1};
        tv[4]  = '{1'b0, 32'h1000, 16'd8, 1'b0, 16'h0000, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 32'h1002, 16'h7FFF, 16'h8000, 8'hFF, 8'h01, 16'd2, 16'd3, 16'd0, 1'b0, 1'b1};
        tv[5]  = '{1'b0, 32'h1000, 16'd8, 1'b0, 16'h0000, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 32'h1002, 16'h7FFF, 16'h8000, 8'hFF, 8'h01, 16'd2, 16'd3, 16'd0, 1'b0, 1'b0};
        tv[6]  = '{1'b1, 32'h3000, 16'd4, 1'b0, 16'h0000, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 32'h1002, 16'h7FFF, 16'h8000, 8'hFF, 8'h01, 16'd2, 16'd0, 16'd0, 1'b0, 1'b0};
        tv[7]  = '{1'b0, 32'h3000, 16'd4, 1'b1, 16'h000A, 16'h0014, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 32'h1002, 16'h7FFF, 16'h8000, 8'hFF, 8'h01, 16'd2, 16'd1, 16'd0, 1'b0, 1'b1};
        tv[8]  = '{1'b0, 32'h3000, 16'd4, 1'b1, 16'h000B, 16'h0015, 8'h01, 8'h01, 1'b1, 1'b1, 1'b1, 32'h3000, 16'h000A, 16'h0014, 8'h00, 8'h00, 16'd0, 16'd2, 16'd0, 1'b0, 1'b1};
        tv[9]  = '{1'b0, 32'h3000, 16'd4, 1'b1, 16'h000C, 16'h0016, 8'h02, 8'h02, 1'b1, 1'b1, 1'b1, 32'h3001, 16'h000B, 16'h0015, 8'h01, 8'h01, 16'd1, 16'd3, 16'd0, 1'b0, 1'b1};
        tv[10] = '{1'b0, 32'h3000, 16'd4, 1'b1, 16'h000D, 16'h0017, 8'h03, 8'h03, 1'b1, 1'b1, 1'b1, 32'h3002, 16'h000C, 16'h0016, 8'h02, 8'h02, 16'd2, 16'd4, 16'd0, 1'b0, 1'b1};
        tv[11] = '{1'b0, 32'h3000, 16'd4, 1'b1, 16'h000E, 16'h0018, 8'h04, 8'h04, 1'b1, 1'b1, 1'b1, 32'h3003, 16'h000D, 16'h0017, 8'h03, 8'h03, 16'd3, 16'd4, 16'd1, 1'b1, 1'b1};
        tv[12] = '{1'b0, 32'h3000, 16'd4, 1'b1, 16'h000F, 16'h0019, 8'h05, 8'h05, 1'b1, 1'b1, 1'b0, 32'h3003, 16'h000D, 16'h0017, 8'h03, 8'h03, 16'd3, 16'd4, 16'd2, 1'b1, 1'b0};
        tv[13] = '{1'b1, 32'h4000, 16'd8, 1'b0, 16'h0000, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 32'h3003, 16'h000D, 16'h0017, 8'h03, 8'h03, 16'd3, 16'd0, 16'd0, 1'b0, 1'b0};

        reset_n = 1'b0; frame_start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
        buffer_base = '0; buffer_limit = '0;
        ev_q = '0; ev_r = '0; ev_depth = '0; ev_mat = '0;
        sb_base = '0; sb_idx = 0; sb_lim = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_event_count", 64'(event_count), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_data", mem_data, 64'd0);
        reset_n = 1'b1;

        for (int k = 0; k < 14; k++) begin
            frame_start = tv[k].fs; buffer_base = tv[k].base; buffer_limit = tv[k].lim;
            in_valid = tv[k].v; ev_q = tv[k].eq; ev_r = tv[k].er;
            ev_depth = tv[k].ed; ev_mat = tv[k].em; mem_ready = tv[k].mr;
            #3;
            chk($sformatf("row%0d_in_ready", k), 64'(in_ready), 64'(tv[k].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_mem_we", k), 64'(mem_we), 64'(tv[k].we));
            chk($sformatf("row%0d_mem_addr", k), 64'(mem_addr), 64'(tv[k].addr));
            chk($sformatf("row%0d_mem_data", k), mem_data,
                rec(tv[k].dq, tv[k].dr, tv[k].dd, tv[k].dm, tv[k].dseq));
            chk($sformatf("row%0d_event_count", k), 64'(event_count), 64'(tv[k].ec));
            chk($sformatf("row%0d_drop_count", k), 64'(drop_count), 64'(tv[k].dc));
            chk($sformatf("row%0d_overflow", k), 64'(overflow), 64'(tv[k].ovf));
            chk($sformatf("row%0d_busy", k), 64'(busy), 64'(tv[k].bsy));
        end

        // Backpressure: output register holds while the FIFO fills
        mon_en = 1'b1;
        new_frame(32'h5000, 100);
        wr_cnt = 0;
        n_acc  = 0;
        for (int c = 0; c < 10; c++) begin
            send(n_acc, 1'b0, acc);
            if (acc) n_acc++;
            if (c >= 1) begin
                chk("bp_hold_we", 64'(mem_we), 64'd1);
                chk("bp_hold_addr", 64'(mem_addr), 64'h5000);
                chk("bp_hold_data", mem_data, rec(fq(0), fr(0), fd(0), fm(0), 16'd0));
            end
        end
        chk("bp_accepts_while_stalled", 64'(n_acc), 64'd9);
        chk("bp_in_ready_low_when_full", 64'(in_ready), 64'd0);
        for (int c = 0; c < 40 && n_acc < 12; c++) begin
            send(n_acc, 1'b1, acc);
            if (acc) n_acc++;
        end
        chk("bp_total_accepts", 64'(n_acc), 64'd12);
        flush("bp_flush");
        chk("bp_write_count", 64'(wr_cnt), 64'd12);

        // Frame boundary with records in flight
        new_frame(32'h6000, 100);
        wr_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            send(40 + c, 1'b0, acc);
            chk("drain_fill_acc", 64'(acc), 64'd1);
        end
        i = 0;
        while (sb_q.size() != 0 && i < 40) begin
            step((i == 0) || (i == 2), 32'h2000, 16'd100, 1'b1, 60, i[0], acc);
            chk("drain_in_ready", 64'(acc), 64'd0);
            i++;
        end
        chk("drain_complete", 64'(sb_q.size()), 64'd0);
        chk("drain_write_count", 64'(wr_cnt), 64'd5);
        sb_base = 32'h2000; sb_idx = 0; sb_lim = 100;
        send(70, 1'b1, acc);
        chk("post_drain_acc0", 64'(acc), 64'd1);
        send(71, 1'b1, acc);
        chk("post_drain_acc1", 64'(acc), 64'd1);
        flush("post_drain_flush");
        repeat (3) step(1'b0, 32'h2000, 16'd100, 1'b0, 0, 1'b1, acc);
        chk("post_drain_event_count", 64'(event_count), 64'd2);

        // Address wrap with an 8-byte stride
        new_frame(32'hFFFF_FFF8, 100);
        addr8_q.delete();
        send(80, 1'b1, acc);
        send(81, 1'b1, acc);
        flush("stride_flush");
        chk("stride_write_count", 64'(addr8_q.size()), 64'd2);
        if (addr8_q.size() == 2) begin
            chk("stride_addr0", 64'(addr8_q[0]), 64'hFFFF_FFF8);
            chk("stride_addr1", 64'(addr8_q[1]), 64'h0000_0000);
        end

        // Zero limit drops everything
        new_frame(32'hB000, 0);
        wr_cnt = 0;
        send(90, 1'b1, acc);
        chk("lim0_acc", 64'(acc), 64'd1);
        send(91, 1'b1, acc);
        repeat (3) step(1'b0, 32'hB000, 16'd0, 1'b0, 0, 1'b1, acc);
        chk("lim0_drop_count", 64'(drop_count), 64'd2);
        chk("lim0_overflow", 64'(overflow), 64'd1);
        chk("lim0_event_count", 64'(event_count), 64'd0);
        chk("lim0_no_writes", 64'(wr_cnt), 64'd0);
        new_frame(32'hC000, 8);
        chk("rebase_clears_drop", 64'(drop_count), 64'd0);
        chk("rebase_clears_overflow", 64'(overflow), 64'd0);

        // Reset mid-frame discards everything pending
        new_frame(32'h9000, 100);
        for (int c = 0; c < 3; c++) send(100 + c, 1'b0, acc);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        step(1'b0, 32'h9000, 16'd100, 1'b0, 0, 1'b0, acc);
        chk("midrst_mem_we", 64'(mem_we), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_event_count", 64'(event_count), 64'd0);
        chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        reset_n = 1'b1;
        sb_q.delete();
        mon_en = 1'b1;
        wr_cnt = 0;
        new_frame(32'hA000, 100);
        send(110, 1'b1, acc);
        flush("midrst_flush");
        chk("midrst_single_write", 64'(wr_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
